// File: rtl/prog_loader_pkg.sv
// prog_loader shared types and constants.
// Imported by the loader FSM and its byte packer.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    WORD,
    WRITE,
    CHK,
    DONE,
    ERR
  } loader_state_t;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream valid/ready handshake into the loader.
// master = byte source, slave = loader.
interface prog_loader_if;

  logic [7:0] byte_i;
  logic       byte_valid;
  logic       byte_ready;

  modport master (
    output byte_i,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_i,
    input  byte_valid,
    output byte_ready
  );

endinterface

// File: rtl/prog_loader_byte_packer.sv
// Packs accepted stream bytes MSB-first into one word.
// last_o flags the byte that completes the word.
module prog_loader_byte_packer
  import prog_loader_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              shift_i,
  input  logic [7:0]        byte_i,
  output logic [DATA_W-1:0] word_o,
  output logic              last_o
);

  logic [DATA_W-1:0] word_q, word_d;
  logic [1:0]        idx_q, idx_d;

  // shift in on accept, clear on load start
  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (clr_i) begin
      word_d = '0;
      idx_d  = '0;
    end else if (shift_i) begin
      word_d = {word_q[DATA_W-9:0], byte_i};
      idx_d  = idx_q + 2'd1;
    end
  end

  // packer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  assign word_o = word_q;
  assign last_o = shift_i
               && (idx_q == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/prog_loader.sv
// Framed boot loader feeding the instruction-memory port.
// Holds the CPU in reset until a frame checksums clean.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MAX_WORDS = 65536
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  prog_loader_if.slave      bus,
  output logic              prog,
  output logic              write,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              cpu_reset,
  output logic              done,
  output logic              err
);

  localparam int CntW = HDR_BYTES * 8;

  loader_state_t     state_q, state_d;
  logic [7:0]        hi_q, hi_d;
  logic [CntW-1:0]   rem_q, rem_d;
  logic [7:0]        csum_q, csum_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              xfer;
  logic              clr;
  logic              shift;
  logic              last;
  logic [CntW-1:0]   hdr_cnt;

  assign xfer    = bus.byte_valid & bus.byte_ready;
  assign hdr_cnt = {hi_q, bus.byte_i};

  prog_loader_byte_packer #(
    .DATA_W (DATA_W)
  ) u_packer (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (clr),
    .shift_i (shift),
    .byte_i  (bus.byte_i),
    .word_o  (data_o),
    .last_o  (last)
  );

  // next-state, counters and running checksum
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    rem_d   = rem_q;
    csum_d  = csum_q;
    addr_d  = addr_q;
    clr     = 1'b0;
    shift   = 1'b0;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = HDR_HI;
          csum_d  = '0;
          addr_d  = BASE_ADDR;
          clr     = 1'b1;
        end
      end
      HDR_HI: begin
        if (xfer) begin
          hi_d    = bus.byte_i;
          csum_d  = csum_q ^ bus.byte_i;
          state_d = HDR_LO;
        end
      end
      HDR_LO: begin
        if (xfer) begin
          csum_d = csum_q ^ bus.byte_i;
          rem_d  = hdr_cnt;
          if (hdr_cnt == '0)
            state_d = CHK;
          else if (32'(hdr_cnt) > 32'(MAX_WORDS))
            state_d = ERR;
          else
            state_d = WORD;
        end
      end
      WORD: begin
        if (xfer) begin
          shift  = 1'b1;
          csum_d = csum_q ^ bus.byte_i;
          if (last) state_d = WRITE;
        end
      end
      WRITE: begin
        addr_d  = addr_q + ADDR_W'(1);
        rem_d   = rem_q - CntW'(1);
        state_d = (rem_q == CntW'(1)) ? CHK : WORD;
      end
      CHK: begin
        if (xfer)
          state_d = (bus.byte_i == csum_q) ? DONE : ERR;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hi_q    <= '0;
      rem_q   <= '0;
      csum_q  <= '0;
      addr_q  <= BASE_ADDR;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      rem_q   <= rem_d;
      csum_q  <= csum_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.byte_ready = state_q inside
    {HDR_HI, HDR_LO, WORD, CHK};
  assign prog = state_q inside
    {HDR_HI, HDR_LO, WORD, WRITE, CHK};
  assign write     = (state_q == WRITE);
  assign cpu_reset = (state_q != DONE);
  assign done      = (state_q == DONE);
  assign err       = (state_q == ERR);
  assign addr_o    = addr_q;

endmodule
